// File: rtl/frame_draw_sequencer.sv
// ---------------------------------------------------------------------------
// frame_draw_sequencer
//
// Purpose:
//   Upstream controller for the per-frame drawers (map, HUD, sprites). On each
//   frame tick it runs the drawers one at a time through enable/done
//   handshakes, drives the VGA write-mux select and records overruns and hung
//   stages. The map is redrawn only after reset or when a redraw is requested.
//
// Handshake (valid/ready style, one rule for all three drawers):
//   <stage>_enable is the request and is high exactly while the sequencer is
//   in that stage. <stage>_done is the drawer's level response; it is sampled
//   only while that stage's enable is high. The stage advances on the edge
//   where done is seen, and the next stage's enable rises on that same edge.
//
// Parameters:
//   TIMEOUT  max cycles a stage may hold enable before being aborted (>= 2)
//   CNT_W    width of the per-stage watchdog counter (2**CNT_W > TIMEOUT)
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   frame_tick            1-cycle pulse at start of vertical blank
//   map_redraw_req        1-cycle pulse: redraw the map on the next frame
//   clear_flags           clears sticky frame_overrun / stage_timeout
//   map/hud/sprite_done   drawer finished (level, valid while enable high)
//   map/hud/sprite_enable run the corresponding drawer
//   vga_sel               0 none, 1 map, 2 HUD, 3 sprite (equals FSM state,
//                         so it doubles as the state debug output)
//   busy                  high whenever the FSM is not IDLE
//   frame_overrun         sticky: frame_tick arrived while busy
//   stage_timeout         sticky {sprite, hud, map}: watchdog expired
//   frame_count           frames completed, wraps 255 -> 0
// ---------------------------------------------------------------------------
module frame_draw_sequencer #(
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       map_redraw_req,
  input  logic       clear_flags,
  input  logic       map_done,
  input  logic       hud_done,
  input  logic       sprite_done,
  output logic       map_enable,
  output logic       hud_enable,
  output logic       sprite_enable,
  output logic [1:0] vga_sel,
  output logic       busy,
  output logic       frame_overrun,
  output logic [2:0] stage_timeout,
  output logic [7:0] frame_count
);

  // State encoding matches the vga_sel codes so the select is the state itself.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAP    = 2'd1,
    S_HUD    = 2'd2,
    S_SPRITE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             map_pending_q, map_pending_d;
  logic             frame_overrun_q, frame_overrun_d;
  logic [2:0]       stage_timeout_q, stage_timeout_d;
  logic [7:0]       frame_count_q, frame_count_d;

  logic             wd_expired;
  logic             overrun_set;
  logic [2:0]       timeout_set;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wd_q            <= '0;
      map_pending_q   <= 1'b1;  // first frame after reset draws the map
      frame_overrun_q <= 1'b0;
      stage_timeout_q <= 3'b000;
      frame_count_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      wd_q            <= wd_d;
      map_pending_q   <= map_pending_d;
      frame_overrun_q <= frame_overrun_d;
      stage_timeout_q <= stage_timeout_d;
      frame_count_q   <= frame_count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    timeout_set   = 3'b000;
    wd_expired    = (wd_q == WD_LAST);
    // Any tick that arrives while a frame is in flight is dropped, including
    // one in the very cycle SPRITE completes (state is still SPRITE then).
    overrun_set   = frame_tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          if (map_pending_q || map_redraw_req) state_d = S_MAP;
          else                                 state_d = S_HUD;
        end
      end
      S_MAP: begin
        // Done has priority over expiry: a drawer finishing on the last
        // allowed cycle is not flagged.
        if (map_done) begin
          state_d = S_HUD;
        end else if (wd_expired) begin
          state_d        = S_HUD;
          timeout_set[0] = 1'b1;
        end
      end
      S_HUD: begin
        if (hud_done) begin
          state_d = S_SPRITE;
        end else if (wd_expired) begin
          state_d        = S_SPRITE;
          timeout_set[1] = 1'b1;
        end
      end
      S_SPRITE: begin
        if (sprite_done || wd_expired) begin
          state_d       = S_IDLE;
          frame_count_d = frame_count_q + 8'd1;
          if (!sprite_done) timeout_set[2] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog restarts on every state change and only runs inside a stage.
    if (state_d != state_q || state_q == S_IDLE) wd_d = '0;
    else                                         wd_d = wd_q + CNT_W'(1);

    // A request that triggers MAP entry is consumed by it; a request seen
    // while already in MAP (no entry this cycle) is kept for the next frame.
    if (state_d == S_MAP && state_q != S_MAP) map_pending_d = 1'b0;
    else                                      map_pending_d = map_pending_q | map_redraw_req;

    // Set events win over a simultaneous clear.
    frame_overrun_d = overrun_set | (frame_overrun_q & ~clear_flags);
    stage_timeout_d = timeout_set | (stage_timeout_q & ~{3{clear_flags}});
  end

  // -------------------------------------------------------------------------
  // Output logic: every output is a pure function of registered state.
  // -------------------------------------------------------------------------
  always_comb begin
    map_enable    = (state_q == S_MAP);
    hud_enable    = (state_q == S_HUD);
    sprite_enable = (state_q == S_SPRITE);
    vga_sel       = state_q;
    busy          = (state_q != S_IDLE);
    frame_overrun = frame_overrun_q;
    stage_timeout = stage_timeout_q;
    frame_count   = frame_count_q;
  end

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_draw_sequencer
//
// Two instances share the stimulus wires but have separate resets: dut_a uses
// the default TIMEOUT for the long map-draw frame, dut_b uses TIMEOUT=16 for
// the table and watchdog sequences. The idle instance is held in reset.
// Outputs are packed as {map_en, hud_en, spr_en, vga_sel, busy, overrun,
// stage_timeout, frame_count}.
// ---------------------------------------------------------------------------
module tb_frame_draw_sequencer;

  localparam int ST_I = 0;
  localparam int ST_M = 1;
  localparam int ST_H = 2;
  localparam int ST_S = 3;

  typedef struct {
    logic        rst;
    logic        tick;
    logic        req;
    logic        clr;
    logic        md;
    logic        hd;
    logic        sd;
    logic [17:0] exp;
  } row_t;

  // ---- clock / reset -------------------------------------------------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic frame_tick = 1'b0, map_redraw_req = 1'b0, clear_flags = 1'b0;
  logic map_done = 1'b0, hud_done = 1'b0, sprite_done = 1'b0;

  logic       a_men, a_hen, a_sen, a_busy, a_ovr;
  logic [1:0] a_sel;
  logic [2:0] a_to;
  logic [7:0] a_fc;
  logic       b_men, b_hen, b_sen, b_busy, b_ovr;
  logic [1:0] b_sel;
  logic [2:0] b_to;
  logic [7:0] b_fc;

  frame_draw_sequencer dut_a (
    .clock(clock), .reset(rst_a), .frame_tick(frame_tick),
    .map_redraw_req(map_redraw_req), .clear_flags(clear_flags),
    .map_done(map_done), .hud_done(hud_done), .sprite_done(sprite_done),
    .map_enable(a_men), .hud_enable(a_hen), .sprite_enable(a_sen),
    .vga_sel(a_sel), .busy(a_busy), .frame_overrun(a_ovr),
    .stage_timeout(a_to), .frame_count(a_fc)
  );

  frame_draw_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut_b (
    .clock(clock), .reset(rst_b), .frame_tick(frame_tick),
    .map_redraw_req(map_redraw_req), .clear_flags(clear_flags),
    .map_done(map_done), .hud_done(hud_done), .sprite_done(sprite_done),
    .map_enable(b_men), .hud_enable(b_hen), .sprite_enable(b_sen),
    .vga_sel(b_sel), .busy(b_busy), .frame_overrun(b_ovr),
    .stage_timeout(b_to), .frame_count(b_fc)
  );

  logic [17:0] out_a, out_b;
  assign out_a = {a_men, a_hen, a_sen, a_sel, a_busy, a_ovr, a_to, a_fc};
  assign out_b = {b_men, b_hen, b_sen, b_sel, b_busy, b_ovr, b_to, b_fc};

  // ---- scoreboard ----------------------------------------------------------
  logic [17:0] exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic        use_a     = 1'b0;

  // Expected packed output for a given state and flag values.
  function automatic logic [17:0] ex(input int st, input logic ovr,
                                     input logic [2:0] to, input logic [7:0] fc);
    logic [2:0] en;
    logic [1:0] sel;
    sel = st[1:0];
    case (st)
      ST_M:    en = 3'b100;
      ST_H:    en = 3'b010;
      ST_S:    en = 3'b001;
      default: en = 3'b000;
    endcase
    return {en, sel, (st != ST_I), ovr, to, fc};
  endfunction

  function automatic row_t mk(input logic rst, tick, req, clr, md, hd, sd,
                              input logic [17:0] exp);
    row_t r;
    r.rst = rst; r.tick = tick; r.req = req; r.clr = clr;
    r.md = md; r.hd = hd; r.sd = sd; r.exp = exp;
    return r;
  endfunction

  // ---- driver: apply inputs for one cycle, check outputs after the edge ----
  task automatic step(input logic rst, tick, req, clr, md, hd, sd,
                      input logic [17:0] exp, input string name);
    logic [17:0] got, want;
    rst_a          = use_a ? rst : 1'b1;
    rst_b          = use_a ? 1'b1 : rst;
    frame_tick     = tick;
    map_redraw_req = req;
    clear_flags    = clr;
    map_done       = md;
    hud_done       = hd;
    sprite_done    = sd;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    got  = use_a ? out_a : out_b;
    want = exp_q.pop_front();
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  task automatic idle_steps(input int n, input logic [17:0] exp, input string name);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, exp, name);
  endtask

  row_t tbl[$];
  logic [7:0] fc;

  initial begin
    // ---- long frame on default-TIMEOUT instance ----------------------------
    use_a = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, ex(ST_I, 0, 3'b000, 0), "a_reset");
    step(0, 1, 0, 0, 0, 0, 0, ex(ST_M, 0, 3'b000, 0), "a_map_start");
    idle_steps(45056, ex(ST_M, 0, 3'b000, 0), "a_map_hold");
    step(0, 0, 0, 0, 1, 0, 0, ex(ST_H, 0, 3'b000, 0), "a_hud");
    step(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 3'b000, 0), "a_sprite");
    step(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 0, 3'b000, 1), "a_frame_done");

    // ---- table on TIMEOUT=16 instance --------------------------------------
    use_a = 1'b0;
    //                rst tk rq cl md hd sd
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, ex(ST_I, 0, 0, 0)));  // reset state
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(ST_I, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, ex(ST_M, 0, 0, 0)));  // first frame: map
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, ex(ST_H, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 0, 0, 1)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, ex(ST_H, 0, 0, 1)));  // no request: skip map
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, ex(ST_H, 0, 0, 1)));  // request during HUD
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, ex(ST_H, 0, 0, 1)));  // foreign dones ignored
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 0, 1)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 0, 0, 2)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, ex(ST_M, 0, 0, 2)));  // pending -> map
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, ex(ST_H, 0, 0, 2)));  // request during MAP kept
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 0, 2)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, ex(ST_I, 1, 0, 3)));  // tick at sprite exit dropped
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, ex(ST_I, 0, 0, 3)));  // clear
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, ex(ST_M, 0, 0, 3)));  // kept request -> map
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, ex(ST_H, 0, 0, 3)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 0, 3)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 0, 0, 4)));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, ex(ST_M, 0, 0, 4)));  // req + tick same cycle
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, ex(ST_H, 0, 0, 4)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 0, 4)));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 0, 0, 5)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, ex(ST_H, 0, 0, 5)));  // that request was consumed
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].tick, tbl[i].req, tbl[i].clr,
           tbl[i].md, tbl[i].hd, tbl[i].sd, tbl[i].exp, $sformatf("row%0d", i));

    // ---- HUD timeout: enable high exactly 16 cycles ------------------------
    idle_steps(15, ex(ST_H, 0, 3'b000, 5), "hud_hold");
    step(0, 0, 0, 0, 0, 0, 0, ex(ST_S, 0, 3'b010, 5), "hud_timeout");
    step(0, 1, 0, 0, 0, 0, 0, ex(ST_S, 1, 3'b010, 5), "overrun_in_sprite");
    step(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 1, 3'b010, 6), "overrun_count_once");
    step(0, 0, 0, 1, 0, 0, 0, ex(ST_I, 0, 3'b000, 6), "clear_flags");

    // ---- done and expiry in the same cycle: no flag ------------------------
    step(0, 1, 0, 0, 0, 0, 0, ex(ST_H, 0, 3'b000, 6), "hud_enter2");
    idle_steps(15, ex(ST_H, 0, 3'b000, 6), "hud_hold2");
    step(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 3'b000, 6), "done_at_expiry");

    // ---- sprite timeout still counts the frame -----------------------------
    idle_steps(15, ex(ST_S, 0, 3'b000, 6), "sprite_hold");
    step(0, 0, 0, 0, 0, 0, 0, ex(ST_I, 0, 3'b100, 7), "sprite_timeout");

    // ---- set beats clear in the same cycle ---------------------------------
    step(0, 1, 0, 0, 0, 0, 0, ex(ST_H, 0, 3'b100, 7), "hud_enter3");
    step(0, 1, 0, 1, 0, 0, 0, ex(ST_H, 1, 3'b000, 7), "set_wins_clear");
    step(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 1, 3'b000, 7), "sprite3");
    step(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 1, 3'b000, 8), "frame8");

    // ---- reset mid-MAP -----------------------------------------------------
    step(0, 0, 1, 0, 0, 0, 0, ex(ST_I, 1, 3'b000, 8), "req_idle");
    step(0, 1, 0, 0, 0, 0, 0, ex(ST_M, 1, 3'b000, 8), "map_enter");
    step(0, 0, 0, 0, 0, 0, 0, ex(ST_M, 1, 3'b000, 8), "map_hold");
    step(1, 0, 0, 0, 0, 0, 0, ex(ST_I, 0, 3'b000, 0), "reset_mid_map");
    step(0, 1, 0, 0, 0, 0, 0, ex(ST_M, 0, 3'b000, 0), "map_after_reset");

    // ---- map timeout -------------------------------------------------------
    idle_steps(15, ex(ST_M, 0, 3'b000, 0), "map_hold2");
    step(0, 0, 0, 0, 0, 0, 0, ex(ST_H, 0, 3'b001, 0), "map_timeout");
    step(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 3'b001, 0), "sprite4");
    step(0, 0, 0, 1, 0, 0, 1, ex(ST_I, 0, 3'b000, 1), "frame_clr");

    // ---- frame_count wrap --------------------------------------------------
    fc = 8'd1;
    for (int f = 0; f < 255; f++) begin
      step(0, 1, 0, 0, 0, 0, 0, ex(ST_H, 0, 3'b000, fc), "wrap_hud");
      step(0, 0, 0, 0, 0, 1, 0, ex(ST_S, 0, 3'b000, fc), "wrap_sprite");
      fc = fc + 8'd1;
      step(0, 0, 0, 0, 0, 0, 1, ex(ST_I, 0, 3'b000, fc), "wrap_count");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
